// File: rtl/wb_regfile_stage_pkg.sv
// Shared sizing, types and limits for the writeback / register-file stage.
package wb_regfile_stage_pkg;
  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters, sticky overflow/underflow flag and
// read-after-write pending detection for the two decode read ports.
module wb_scoreboard
  import wb_regfile_stage_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      wb_valid,
  input  reg_addr_t wb_addr,
  input  logic      issue_valid,
  input  reg_addr_t issue_addr,
  input  reg_addr_t rd_addr_a,
  input  logic      rd_use_a,
  input  reg_addr_t rd_addr_b,
  input  logic      rd_use_b,
  output logic      pend_a,
  output logic      pend_b,
  output logic      sb_err
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NUM_REGS-1:0]            inc_vec, dec_vec, bad_vec;

  // Register 0 is masked out so its counter never leaves zero.
  assign inc_vec = {NUM_REGS{issue_valid}} & (NUM_REGS'(1) << issue_addr) & ~NUM_REGS'(1);
  assign dec_vec = {NUM_REGS{wb_valid}}    & (NUM_REGS'(1) << wb_addr)    & ~NUM_REGS'(1);

  always_comb begin
    cnt_nxt = cnt;
    bad_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt[r] == CNT_MAX) bad_vec[r] = 1'b1;
        else                   cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt[r] == '0) bad_vec[r] = 1'b1;
        else              cnt_nxt[r] = cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      sb_err <= 1'b0;
    end else if (en) begin
      cnt    <= cnt_nxt;
      sb_err <= sb_err | (|bad_vec);
    end
  end

  // The last outstanding write landing this cycle is covered by the bypass.
  assign pend_a = rd_use_a && (rd_addr_a != '0) && (cnt[rd_addr_a] != '0) &&
                  !((cnt[rd_addr_a] == CNT_W'(1)) && en && wb_valid && (wb_addr == rd_addr_a));
  assign pend_b = rd_use_b && (rd_addr_b != '0) && (cnt[rd_addr_b] != '0) &&
                  !((cnt[rd_addr_b] == CNT_W'(1)) && en && wb_valid && (wb_addr == rd_addr_b));
endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: commits results into an 8-entry register file, serves two
// bypassed read ports and reports decode hazards from the scoreboard.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_use_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_use_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              hazard,
  output logic              sb_err
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  wb_req_t wb;
  logic    wb_fire, pend_a, pend_b;

  assign wb      = '{valid: wb_valid, addr: wb_addr, data: wb_data};
  // Held in reset the stage shows all-zero reads, so the bypass is gated too.
  assign wb_fire = reset && en && wb.valid && (wb.addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       regs          <= '0;
    else if (wb_fire) regs[wb.addr] <= wb.data;
  end

  assign rd_data_a = (wb_fire && (wb.addr == rd_addr_a)) ? wb.data : regs[rd_addr_a];
  assign rd_data_b = (wb_fire && (wb.addr == rd_addr_b)) ? wb.data : regs[rd_addr_b];

  wb_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_use_a    (rd_use_a),
    .rd_addr_b   (rd_addr_b),
    .rd_use_b    (rd_use_b),
    .pend_a      (pend_a),
    .pend_b      (pend_b),
    .sb_err      (sb_err)
  );

  assign hazard = pend_a || pend_b;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Randomized and directed checks of wb_regfile_stage against an array model.
module tb_wb_regfile_stage;
  logic       clk = 1'b0;
  logic       reset, en, wb_valid, issue_valid, rd_use_a, rd_use_b;
  logic [2:0] wb_addr, issue_addr, rd_addr_a, rd_addr_b;
  logic [9:0] wb_data, rd_data_a, rd_data_b;
  logic       hazard, sb_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: register contents, outstanding-write counts, error flag.
  int m_reg [8];
  int m_cnt [8];
  bit m_err;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .en(en),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr_a(rd_addr_a), .rd_use_a(rd_use_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_use_b(rd_use_b), .rd_data_b(rd_data_b),
    .hazard(hazard), .sb_err(sb_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_cnt[i] = 0; end
    m_err = 0;
  endtask

  function automatic bit writing(input logic [2:0] a);
    return reset && en && wb_valid && wb_addr == a && a != 0;
  endfunction

  function automatic int exp_rd(input logic [2:0] a);
    if (a == 0)     return 0;
    if (writing(a)) return int'(wb_data);
    return m_reg[a];
  endfunction

  function automatic bit exp_pend(input bit use_x, input logic [2:0] a);
    if (!use_x || a == 0 || m_cnt[a] == 0) return 0;
    if (m_cnt[a] == 1 && en && wb_valid && wb_addr == a) return 0;
    return 1;
  endfunction

  task automatic drive(input bit e, input bit wv, input int wa, input int wd,
                       input bit iv, input int ia,
                       input int ra, input bit ua, input int rb, input bit ub);
    en = e; wb_valid = wv; wb_addr = 3'(wa); wb_data = 10'(wd);
    issue_valid = iv; issue_addr = 3'(ia);
    rd_addr_a = 3'(ra); rd_use_a = ua; rd_addr_b = 3'(rb); rd_use_b = ub;
  endtask

  // Check outputs against the model, clock once, advance the model.
  task automatic cyc();
    #1;
    check("rd_data_a", int'(rd_data_a), exp_rd(rd_addr_a));
    check("rd_data_b", int'(rd_data_b), exp_rd(rd_addr_b));
    check("hazard", int'(hazard), int'(exp_pend(rd_use_a, rd_addr_a) || exp_pend(rd_use_b, rd_addr_b)));
    check("sb_err", int'(sb_err), int'(m_err));
    @(posedge clk);
    if (!reset) model_clear();
    else if (en) begin
      for (int r = 1; r < 8; r++) begin
        bit inc = issue_valid && issue_addr == r;
        bit dec = wb_valid && wb_addr == r;
        if (inc && !dec) begin
          if (m_cnt[r] == 3) m_err = 1; else m_cnt[r]++;
        end else if (dec && !inc) begin
          if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
        end
      end
      if (wb_valid && wb_addr != 0) m_reg[wb_addr] = int'(wb_data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_clear();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset held while a writeback is presented.
    reset = 1'b0;
    model_clear();
    drive(1, 1, 3, 'h2AA, 0, 0, 3, 1, 3, 0);
    cyc();
    cyc();
    #1 check("reset_rd3", int'(rd_data_a), 0);
    check("reset_hazard", int'(hazard), 0);
    check("reset_err", int'(sb_err), 0);
    drive(1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    reset = 1'b1;
    cyc();

    // Bypass then storage.
    drive(1, 1, 5, 'h155, 0, 0, 5, 0, 0, 0);
    #1 check("bypass_rd5", int'(rd_data_a), 'h155);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    #1 check("stored_rd5", int'(rd_data_a), 'h155);
    cyc();

    // Register 0 protection.
    do_reset();
    drive(1, 1, 0, 'h3FF, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 check("r0_rd", int'(rd_data_b), 0);
    check("r0_hazard", int'(hazard), 0);
    cyc();

    // Hazard lifecycle on register 2.
    do_reset();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    #1 check("raw_hazard", int'(hazard), 1);
    cyc();
    drive(1, 1, 2, 'h1A5, 0, 0, 2, 1, 0, 0);
    #1 check("wb_clears_hazard", int'(hazard), 0);
    check("wb_bypass_rd2", int'(rd_data_a), 'h1A5);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    #1 check("cnt_zero_after", int'(hazard), 0);
    check("no_err_lifecycle", int'(sb_err), 0);
    cyc();

    // Counter saturation at 3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      cyc();
    end
    drive(1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    #1 check("overflow_err", int'(sb_err), 1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 4, i, 0, 0, 4, 1, 0, 0);
      cyc();
    end
    drive(1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    #1 check("sat_cnt_still_pending", int'(hazard), 1);
    cyc();

    // Underflow on first edge after reset still writes.
    do_reset();
    drive(1, 1, 6, 'h0AB, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 6, 0, 0, 0);
    #1 check("underflow_err", int'(sb_err), 1);
    check("underflow_write", int'(rd_data_a), 'h0AB);
    cyc();

    // Simultaneous issue and writeback at zero.
    do_reset();
    drive(1, 1, 7, 'h077, 1, 7, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    #1 check("inc_dec_no_err", int'(sb_err), 0);
    check("inc_dec_no_hazard", int'(hazard), 0);
    cyc();

    // Stall freezes state and suppresses bypass.
    do_reset();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 1, 'h111, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 1, 1, 'h0F0, 1, 1, 1, 1, 0, 0);
    #1 check("stall_no_bypass", int'(rd_data_a), 'h111);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 check("stall_kept_data", int'(rd_data_a), 'h111);
    check("stall_kept_cnt", int'(hazard), 0);
    cyc();

    // Randomized traffic with occasional stalls and resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1023)), $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), $urandom_range(0, 1), int'($urandom_range(0, 7)),
            $urandom_range(0, 1));
      reset = ($urandom_range(0, 99) != 0);
      if (!reset) model_clear();
      cyc();
    end
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
